sha_msg_sched_stream: RTL and testbench
=======================================

SHA_MSG_SCHED_STREAM -- requirements
Module: sha_msg_sched_stream

Interface
REQ-001 SHALL have parameter LANE_W, default 1; meaning: W words emitted per output beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter ROUNDS, default 64; meaning: total W words emitted per block; multiple of LANE_W, range 16..64.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit; synchronous abort of the current block.
REQ-006 SHALL have port m_valid, input, 1 bit; message word M_t present.
REQ-007 SHALL have port m_data, input, 32 bits; message word, loaded in order M_0..M_15.
REQ-008 SHALL have port m_ready, output, 1 bit; block accepts a message word.
REQ-009 SHALL have port w_valid, output, 1 bit; output beat present.
REQ-010 SHALL have port w_data, output, 32*LANE_W bits; W_t in bits [31:0], W_t+1 in [63:32], and so on.
REQ-011 SHALL have port w_index, output, 6 bits; t, the index of the word in w_data[31:0].
REQ-012 SHALL have port w_last, output, 1 bit; beat contains W_(ROUNDS-1).
REQ-013 SHALL have port w_ready, input, 1 bit; consumer accepts the beat.
REQ-014 SHALL have port busy, output, 1 bit; high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, EMIT.
REQ-016 SHALL go from IDLE to LOAD on the first accepted word (m_valid && m_ready).
REQ-017 SHALL go from LOAD to EMIT on acceptance of the 16th word.
REQ-018 SHALL go from EMIT to IDLE on acceptance of the w_last beat.
REQ-019 SHALL assert m_ready exactly in IDLE and LOAD; a word is taken only when m_valid && m_ready.
REQ-020 SHALL hold a 16-word window; each accepted input word shifts in at the newest position.
REQ-021 SHALL hold a 6-bit load counter that wraps to 0 after word 15.
REQ-022 SHALL assert w_valid exactly in EMIT; w_valid is registered-state based, and the first beat appears the cycle after M_15 is accepted.
REQ-023 SHALL emit W_t = M_t for t<16.
REQ-024 SHALL emit W_t = sigma1(W_t-2) + W_t-7 + sigma0(W_t-15) + W_t-16 mod 2^32 for t>=16.
REQ-025 SHALL define sigma0 = ROTR7 ^ ROTR18 ^ SHR3.
REQ-026 SHALL define sigma1 = ROTR17 ^ ROTR19 ^ SHR10.
REQ-027 SHALL chain within a beat when LANE_W>1: lane k uses lanes <k of the same beat as operands where t-2 or t-7 fall inside the beat.
REQ-028 SHALL advance the window by LANE_W words and w_index by LANE_W only on w_valid && w_ready.
REQ-029 SHALL, while w_ready=0, hold w_data, w_index and w_last stable with w_valid high.
REQ-030 SHALL set w_index=0 on the first beat and assert w_last when w_index+LANE_W == ROUNDS.
REQ-031 SHALL NOT accept input during EMIT; a new block may start loading the cycle after the w_last handshake.
REQ-032 SHALL, on flush=1 in any state, go to IDLE next cycle, clear the counters, and drop w_valid; flush overrides a same-cycle input or output handshake, and neither word is consumed.
REQ-033 SHALL ignore m_data when m_valid=0; gaps in m_valid during LOAD simply pause loading.

Reset
REQ-034 SHALL, on reset_n=0 asserted at any time including mid-LOAD or mid-EMIT, immediately force state IDLE, counters 0, and window 0.
REQ-035 SHALL hold these reset output values: w_valid=0, w_last=0, w_index=0, w_data=0, busy=0, m_ready=0 while reset_n=0.
REQ-036 SHALL assert m_ready=1 on the first cycle after reset_n deasserts.

Verification
REQ-037 SHALL test the FIPS "abc" block, LANE_W=1, w_ready=1: M_0=0x61626380, M_1..M_14=0, M_15=0x00000018 -> W_16=0x61626380, W_17=0x000F0000, 64 beats, w_last on w_index=63, then m_ready=1.
REQ-038 SHALL test the same block with LANE_W=4: 16 beats; w_index 0,4,...,60; every word matches the LANE_W=1 run bit-exactly.
REQ-039 SHALL test backpressure: w_ready randomly 0 for 1-5 cycles -> no word lost or duplicated; w_data stable while stalled; output sequence identical to REQ-037.
REQ-040 SHALL test ROUNDS=16: w_last is on w_index=15 and W_t == M_t throughout; m_valid gaps during LOAD -> same result.
REQ-041 SHALL test flush at w_index=20 -> w_valid=0 next cycle, busy=0; a following "abc" load then reproduces REQ-037 exactly.
REQ-042 SHALL test reset_n pulsed low mid-LOAD after 7 words -> all outputs 0 asynchronously; a reload of 16 words gives a correct schedule.

Source files
------------

// File: rtl/sha_msg_sched_stream.sv
// SHA-256 message schedule generator: loads M_0..M_15 over a valid/ready stream, then emits
// W_0..W_(ROUNDS-1) in beats of LANE_W words from a sliding 16-word window.
module sha_msg_sched_stream #(
    parameter int unsigned LANE_W = 1,
    parameter int unsigned ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  m_valid,
    input  logic [31:0]           m_data,
    output logic                  m_ready,
    output logic                  w_valid,
    output logic [32*LANE_W-1:0]  w_data,
    output logic [5:0]            w_index,
    output logic                  w_last,
    input  logic                  w_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

    state_e                  state_q, state_d;
    logic [5:0]              load_cnt_q, load_cnt_d;
    logic [5:0]              idx_q, idx_d;
    logic [15:0][31:0]       win_q, win_d;
    logic [LANE_W-1:0][31:0] nw_words;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window holds W_t..W_t+15 with the oldest at index 0; the words that follow it are
    // computed in order so later lanes can use earlier lanes of the same beat as operands.
    function automatic logic [LANE_W-1:0][31:0] next_words(input logic [15:0][31:0] win);
        logic [15+LANE_W:0][31:0] ext;
        ext = '0;
        ext[15:0] = win;
        for (int j = 16; j < 16 + int'(LANE_W); j++) begin
            ext[j] = sig1(ext[j-2]) + ext[j-7] + sig0(ext[j-15]) + ext[j-16];
        end
        return ext[15+LANE_W:16];
    endfunction

    assign nw_words = next_words(win_q);

    always_comb begin
        w_valid = (state_q == StEmit);
        busy    = (state_q != StIdle);
        m_ready = reset_n && (state_q != StEmit);
        w_index = idx_q;
        w_data  = w_valid ? win_q[LANE_W-1:0] : '0;
        w_last  = w_valid && (({1'b0, idx_q} + 7'(LANE_W)) == 7'(ROUNDS));
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        idx_d      = idx_q;
        win_d      = win_q;
        if (flush) begin
            state_d    = StIdle;
            load_cnt_d = '0;
            idx_d      = '0;
        end else begin
            unique case (state_q)
                StIdle, StLoad: begin
                    if (m_valid) begin
                        win_d = {m_data, win_q[15:1]};
                        if (load_cnt_q == 6'd15) begin
                            load_cnt_d = '0;
                            idx_d      = '0;
                            state_d    = StEmit;
                        end else begin
                            load_cnt_d = load_cnt_q + 6'd1;
                            state_d    = StLoad;
                        end
                    end
                end
                StEmit: begin
                    if (w_ready) begin
                        win_d = {nw_words, win_q[15:LANE_W]};
                        if (w_last) begin
                            idx_d   = '0;
                            state_d = StIdle;
                        end else begin
                            idx_d = idx_q + 6'(LANE_W);
                        end
                    end
                end
                default: begin
                    state_d    = StIdle;
                    load_cnt_d = '0;
                    idx_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            idx_q      <= '0;
            win_q      <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            idx_q      <= idx_d;
            win_q      <= win_d;
        end
    end

endmodule

// File: tb/tb_sha_msg_sched_stream.sv
// Scoreboard bench for sha_msg_sched_stream: three instances (LANE_W=1/64, LANE_W=4/64,
// LANE_W=1/16); expected beats are queued at issue time and popped by a negedge monitor.
module tb_sha_msg_sched_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, w_ready;
    logic [31:0] m_data;
    logic [2:0]  m_valid, m_ready, w_valid, w_last, busy;
    logic [5:0]  w_index [3];
    logic [31:0] wd_a, wd_c;
    logic [127:0] wd_b;
    logic [127:0] wd [3];

    assign wd[0] = {96'b0, wd_a};
    assign wd[1] = wd_b;
    assign wd[2] = {96'b0, wd_c};

    sha_msg_sched_stream #(.LANE_W(1), .ROUNDS(64)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .m_valid(m_valid[0]), .m_data(m_data),
        .m_ready(m_ready[0]), .w_valid(w_valid[0]), .w_data(wd_a), .w_index(w_index[0]),
        .w_last(w_last[0]), .w_ready(w_ready), .busy(busy[0]));

    sha_msg_sched_stream #(.LANE_W(4), .ROUNDS(64)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .m_valid(m_valid[1]), .m_data(m_data),
        .m_ready(m_ready[1]), .w_valid(w_valid[1]), .w_data(wd_b), .w_index(w_index[1]),
        .w_last(w_last[1]), .w_ready(w_ready), .busy(busy[1]));

    sha_msg_sched_stream #(.LANE_W(1), .ROUNDS(16)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .flush(flush), .m_valid(m_valid[2]), .m_data(m_data),
        .m_ready(m_ready[2]), .w_valid(w_valid[2]), .w_data(wd_c), .w_index(w_index[2]),
        .w_last(w_last[2]), .w_ready(w_ready), .busy(busy[2]));

    typedef struct packed {
        logic [1:0]   dut;
        logic [127:0] data;
        logic [5:0]   idx;
        logic         last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic        abc_mode = 1'b0;
    logic        bp_en = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic gen_sched();
        for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        abc_mode = 1'b1;
        gen_sched();
    endtask

    task automatic push_block(input int d, input int lane, input int rounds);
        beat_t b;
        for (int n = 0; n < rounds / lane; n++) begin
            b.dut  = 2'(d);
            b.data = '0;
            for (int k = 0; k < lane; k++) b.data[32*k +: 32] = exp_w[n*lane + k];
            b.idx  = 6'(n * lane);
            b.last = (n * lane + lane == rounds);
            exp_q.push_back(b);
        end
    endtask

    task automatic load_words(input int d, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                m_valid[d] = 1'b0;
                m_data     = $urandom;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            m_valid[d] = 1'b1;
            m_data     = msg[i];
            check($sformatf("m_ready d%0d word %0d", d, i), 160'(m_ready[d]), 160'(1));
            @(posedge clk);
            #1;
        end
        m_valid[d] = 1'b0;
        m_data     = $urandom;
    endtask

    task automatic load_block(input int d, input bit gaps);
        load_words(d, 16, gaps);
        check($sformatf("first beat d%0d", d), {w_valid[d], m_ready[d], w_index[d]},
              {1'b1, 1'b0, 6'd0});
    endtask

    task automatic wait_drain(input int d, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || w_valid[d]) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " drained"}, 160'(n < 2000), 160'(1));
        check({name, " idle after last"}, {m_ready[d], busy[d], w_valid[d]}, 3'b100);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    // Random backpressure: w_ready low for 1-5 cycle stretches when enabled.
    initial begin
        int stall_n = 0;
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) begin
                w_ready = 1'b1;
            end else if (stall_n > 0) begin
                w_ready = 1'b0;
                stall_n--;
            end else if ($urandom_range(0, 2) == 0) begin
                w_ready = 1'b0;
                stall_n = $urandom_range(0, 4);
            end else begin
                w_ready = 1'b1;
            end
        end
    end

    // Monitor: pops on each beat that will handshake at the coming edge; checks hold on stall.
    initial begin
        logic         stalled = 1'b0;
        int           st_d = 0;
        logic [134:0] st_snap = '0;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (!reset_n || flush) begin
                stalled = 1'b0;
            end else begin
                if (stalled && w_valid[st_d])
                    check($sformatf("stall hold d%0d", st_d),
                          160'({wd[st_d], w_index[st_d], w_last[st_d]}), 160'(st_snap));
                stalled = 1'b0;
                for (int d = 0; d < 3; d++) begin
                    if (w_valid[d] && w_ready) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("unexpected beat d%0d i%0d", d, w_index[d]),
                                  160'(1), 160'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("beat dut d%0d", d), 160'(d), 160'(e.dut));
                            check($sformatf("beat d%0d i%0d", d, e.idx),
                                  {wd[d], w_index[d], w_last[d]}, {e.data, e.idx, e.last});
                        end
                        if (abc_mode && d == 0 && w_index[d] == 6'd16)
                            check("abc W16", 160'(wd[0][31:0]), 160'(32'h61626380));
                        if (abc_mode && d == 0 && w_index[d] == 6'd17)
                            check("abc W17", 160'(wd[0][31:0]), 160'(32'h000F0000));
                        if (abc_mode && d == 1 && w_index[d] == 6'd16)
                            check("abc lane4 W16/W17", 160'(wd[1][63:0]),
                                  160'(64'h000F0000_61626380));
                    end else if (w_valid[d]) begin
                        stalled = 1'b1;
                        st_d    = d;
                        st_snap = {wd[d], w_index[d], w_last[d]};
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        flush   = 1'b0;
        m_valid = '0;
        m_data  = '0;
        @(negedge clk);
        check("reset flags", {m_ready, w_valid, w_last, busy}, 12'h000);
        for (int d = 0; d < 3; d++)
            check($sformatf("reset data/index d%0d", d), {wd[d], w_index[d]}, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("m_ready after reset", 160'(m_ready), 160'(3'b111));

        // abc block, one lane
        set_abc();
        push_block(0, 1, 64);
        load_block(0, 1'b0);
        wait_drain(0, "abc lane1");

        // abc block, four lanes
        push_block(1, 4, 64);
        load_block(1, 1'b0);
        wait_drain(1, "abc lane4");

        // abc block under random backpressure
        bp_en = 1'b1;
        push_block(0, 1, 64);
        load_block(0, 1'b0);
        wait_drain(0, "abc backpressure");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // ROUNDS=16: pass-through, with and without m_valid gaps
        abc_mode = 1'b0;
        for (int i = 0; i < 16; i++) msg[i] = 32'h9E3779B9 * (i + 1) ^ 32'h0BADF00D;
        gen_sched();
        push_block(2, 1, 16);
        load_block(2, 1'b0);
        wait_drain(2, "rounds16");
        push_block(2, 1, 16);
        load_block(2, 1'b1);
        wait_drain(2, "rounds16 gaps");

        // flush while beat 20 is presented, then a clean reload
        set_abc();
        push_block(0, 1, 64);
        load_block(0, 1'b0);
        n = 0;
        while (!(w_valid[0] && w_index[0] == 6'd20) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached index 20", 160'(n < 200), 160'(1));
        flush = 1'b1;
        check("beats left at flush", 160'(exp_q.size()), 160'(44));
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("after flush", {w_valid[0], busy[0], m_ready[0]}, 3'b001);
        exp_q.delete();
        push_block(0, 1, 64);
        load_block(0, 1'b0);
        wait_drain(0, "abc after flush");

        // asynchronous reset mid-LOAD after 7 words, then a full reload
        load_words(0, 7, 1'b0);
        check("busy mid load", 160'(busy[0]), 160'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset flags", {m_ready, w_valid, w_last, busy}, 12'h000);
        check("async reset data a", {wd[0], w_index[0]}, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("m_ready after mid-load reset", 160'(m_ready[0]), 160'(1));
        @(posedge clk);
        #1;
        push_block(0, 1, 64);
        load_block(0, 1'b0);
        wait_drain(0, "abc after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
